uart_byte_receiver: RTL

Serial-input front end for the processor's ',' (read byte) instruction, running in the fast clk domain.
- Deserialises 8N1 UART frames from an external pin.
- Presents each received byte on a holding register with a one-cycle data_valid strobe.
- data_valid feeds directly into clockCatcher's `in`, which stretches it for the slow processor clock.
- Framing errors are flagged and never produce a strobe.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/rx_synchronizer.sv | 28 ++
 rtl/uart_byte_receiver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART byte receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int UART_DATA_BITS = 8;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchroniser for an asynchronous input pin. Resets to RST_VAL so an
// idle-high line (UART rx, pulled-up buttons) never looks active out of reset.
module rx_synchronizer #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; the first stage may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// UART byte receiver: deserialises 8N1 frames (8E1 when UART_RX_PARITY_EN is
// defined) from an idle-high serial pin. Good bytes land in a holding register
// with a one-cycle data_valid strobe; bad stop bits give a one-cycle
// framing_error and park in BREAK until the line returns high.
module uart_byte_receiver
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  // Full bit period and half bit period terminal counts.
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 pe_q, pe_d;
`endif

  rx_synchronizer #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (rx),
    .sync_o  (rx_s)
  );

  // Register stage: state, timing counters, shift register and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  // Frame sequencing: every sample is taken at mid-bit, timed from the start edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high here was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            idx_d   = '0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        // LSB arrives first: shift in at the top so it ends up at bit 0.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        // Leaving mid-stop-bit lets a start bit that follows immediately be caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              pe_d = 1'b1;
            end else begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end
`else
            data_d = shift_q;
            dv_d   = 1'b1;
`endif
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // A held-low line must go high before another start bit is accepted.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data          = data_q;
  assign data_valid    = dv_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule
